// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared constants, FSM state types and parity helper for the UART link channel
package uart_link_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;
    localparam int OVERSAMPLE  = 16;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Zero-extending narrower frames to 9 bits leaves the XOR reduction unchanged.
    function automatic logic parity_bit(input int mode, input logic [8:0] d);
        return (mode == PARITY_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/uart_link_channel.sv
// uart_link_channel: FIFO-buffered UART with sticky error flags and timed module-reset pulse
module uart_link_channel
    import uart_link_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int RST_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic                          rxd,
    output logic                          txd,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          err_clear,
    input  logic                          module_reset_req,
    output logic                          module_reset_n
);

    localparam int DIV = CLK_HZ / (OVERSAMPLE * BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW  = $clog2(RST_CYCLES + 1);

    logic [DW-1:0] div_q, div_d;
    logic          tick;

    assign tick  = div_q == DW'(DIV - 1);
    assign div_d = tick ? '0 : div_q + DW'(1);

    // Free-running oversample tick divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= div_d;
    end

    logic rxd_meta_q, rxd_sync_q;

    // Two-flop synchroniser for the asynchronous serial input, idling high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    logic [DATA_BITS-1:0] tx_head, rx_wdata;
    logic                 tx_full, tx_empty, tx_pop;
    logic                 rx_full, rx_empty, rx_push, rx_pop;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (tx_valid && tx_ready),
        .pop   (tx_pop),
        .din   (tx_data),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_wdata),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    tx_state_t            tx_state_q, tx_state_d;
    logic [3:0]           tx_os_q, tx_os_d, tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_bit_end;

    assign tx_bit_end = tick && tx_os_q == 4'd15;
    // Reloading straight from STOP keeps back-to-back frames gap-free.
    assign tx_pop = !tx_empty && ((tick && tx_state_q == TX_IDLE) ||
                                  (tx_bit_end && tx_state_q == TX_STOP));
    assign txd    = (tx_state_q == TX_START)  ? 1'b0 :
                    (tx_state_q == TX_DATA)   ? tx_shift_q[0] :
                    (tx_state_q == TX_PARITY) ? tx_par_q : 1'b1;

    // TX frame sequencer: start, data LSB first, optional parity, stop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = (tick && tx_state_q != TX_IDLE) ? tx_os_q + 4'd1 : tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            TX_START:  if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = 4'd0;
            end
            TX_DATA:   if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'(DATA_BITS - 1))
                    tx_state_d = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
            TX_STOP:   if (tx_bit_end) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_d = TX_START;
            tx_os_d    = 4'd0;
            tx_shift_d = tx_head;
            tx_par_d   = parity_bit(PARITY, 9'(tx_head));
        end
    end

    // TX FSM registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
        end
    end

    rx_state_t            rx_state_q, rx_state_d;
    logic [3:0]           rx_os_q, rx_os_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d, rx_bit_end, rx_mid, rx_par_bad;
    logic                 fe_set, pe_set, ov_set;

    assign rx_bit_end = tick && rx_os_q == 4'd15;
    assign rx_mid     = tick && rx_os_q == 4'd7;
    assign rx_wdata   = rx_shift_q;
    assign rx_par_bad = (PARITY != PARITY_NONE) &&
                        (rx_par_q != parity_bit(PARITY, 9'(rx_shift_q)));

    // RX frame sampler: mid-bit sampling, glitch rejection, frame validation.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = (tick && rx_state_q != RX_IDLE) ? rx_os_q + 4'd1 : rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        pe_set     = 1'b0;
        ov_set     = 1'b0;
        case (rx_state_q)
            RX_IDLE:   if (!rxd_sync_q) begin
                rx_state_d = RX_START;
                rx_os_d    = 4'd0;
            end
            RX_START:  if (rx_mid) begin
                rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                rx_os_d    = 4'd0;
                rx_bit_d   = 4'd0;
            end
            RX_DATA:   if (rx_bit_end) begin
                rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
                if (rx_bit_q == 4'(DATA_BITS - 1))
                    rx_state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_bit_end) begin
                rx_par_d   = rxd_sync_q;
                rx_state_d = RX_STOP;
            end
            RX_STOP:   if (rx_bit_end) begin
                rx_state_d = RX_IDLE;
                fe_set     = !rxd_sync_q;
                pe_set     = rx_par_bad;
                ov_set     = rxd_sync_q && !rx_par_bad && rx_full && !rx_pop;
                rx_push    = rxd_sync_q && !rx_par_bad && (!rx_full || rx_pop);
            end
            default:   rx_state_d = RX_IDLE;
        endcase
    end

    // RX FSM registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
        end
    end

    logic fe_q, pe_q, ov_q;

    assign framing_err = fe_q;
    assign parity_err  = pe_q;
    assign overflow    = ov_q;

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fe_q <= 1'b0;
            pe_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            fe_q <= fe_set | (fe_q & ~err_clear);
            pe_q <= pe_set | (pe_q & ~err_clear);
            ov_q <= ov_set | (ov_q & ~err_clear);
        end
    end

    logic          mr_req_q, mr_edge, mr_n_q;
    logic [RW-1:0] mr_cnt_q, mr_cnt_d;

    assign mr_edge        = module_reset_req && !mr_req_q;
    assign mr_cnt_d       = mr_edge ? RW'(RST_CYCLES) :
                            (mr_cnt_q != '0) ? mr_cnt_q - RW'(1) : mr_cnt_q;
    assign module_reset_n = mr_n_q;

    // Module reset pulse timer; each request edge restarts the full count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mr_req_q <= 1'b0;
            mr_cnt_q <= '0;
            mr_n_q   <= 1'b1;
        end else begin
            mr_req_q <= module_reset_req;
            mr_cnt_q <= mr_cnt_d;
            mr_n_q   <= mr_cnt_d == '0;
        end
    end

endmodule

// File: tb/tb_uart_link_channel.sv
// tb_uart_link_channel: directed self-checking bench for uart_link_channel
module tb_uart_link_channel;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [4:0] tx_count, rx_count;
    logic       rxd, txd;
    logic       framing_err, parity_err, overflow;
    logic       err_clear = 1'b0;
    logic       module_reset_req = 1'b0;
    logic       module_reset_n;
    logic       loop = 1'b0;
    logic       rxd_drv = 1'b1;
    int         checks = 0;
    int         failures = 0;

    assign rxd = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_link_channel #(
        .CLK_HZ     (1600000),
        .BAUD       (100000),
        .DATA_BITS  (8),
        .PARITY     (2),
        .FIFO_DEPTH (16),
        .RST_CYCLES (10)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_count         (tx_count),
        .rx_count         (rx_count),
        .rxd              (rxd),
        .txd              (txd),
        .framing_err      (framing_err),
        .parity_err       (parity_err),
        .overflow         (overflow),
        .err_clear        (err_clear),
        .module_reset_req (module_reset_req),
        .module_reset_n   (module_reset_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd_drv = b;
        cyc(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        check(tag, rx_data, exp);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        cyc(1);
        err_clear = 1'b0;
    endtask

    task automatic mr_pulse(input bit restart, output int low);
        low = 0;
        module_reset_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (!module_reset_n) low++;
            module_reset_req = restart && k == 4;
        end
    endtask

    initial begin
        logic [10:0] fr;
        logic [7:0]  d;
        int          low;
        cyc(3);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_txd", txd, 1);
        check("rst_errs", {framing_err, parity_err, overflow}, 0);
        check("rst_mod_n", module_reset_n, 1);
        reset_n = 1'b1;
        cyc(2);

        push_tx(8'hA5);
        check("tx_count_push", tx_count, 1);
        cyc(1);
        check("tx_count_pop", tx_count, 0);
        fr = {1'b1, 1'b0, 8'hA5, 1'b0};
        for (int c = 0; c < 176; c++) begin
            if (c % 16 == 0 || c % 16 == 15) check($sformatf("tx_bit%0d_%0d", c / 16, c % 16), txd, fr[c / 16]);
            cyc(1);
        end
        check("tx_idle", txd, 1);

        loop = 1'b1;
        push_tx(8'h00);
        push_tx(8'hFF);
        push_tx(8'h3C);
        for (int i = 0; i < 1000 && rx_count != 5'd3; i++) cyc(1);
        check("lb_count", rx_count, 3);
        pop_rx("lb_0", 8'h00);
        pop_rx("lb_1", 8'hFF);
        pop_rx("lb_2", 8'h3C);
        check("lb_empty", rx_valid, 0);
        check("lb_errs", {framing_err, parity_err, overflow}, 0);
        loop = 1'b0;
        cyc(20);

        send_frame(8'h55, 1'b0, 1'b0);
        check("fe_set", framing_err, 1);
        check("fe_pe", parity_err, 0);
        check("fe_count", rx_count, 0);
        clear_errs();
        check("fe_clear", framing_err, 0);

        send_frame(8'h01, 1'b0, 1'b1);
        check("pe_set", parity_err, 1);
        check("pe_fe", framing_err, 0);
        check("pe_count", rx_count, 0);
        clear_errs();
        check("pe_clear", parity_err, 0);

        for (int i = 0; i < 16; i++) begin
            d = 8'h10 + 8'(i);
            send_frame(d, ^d, 1'b1);
        end
        check("ov_fill", rx_count, 16);
        check("ov_pre", overflow, 0);
        send_frame(8'hEE, 1'b0, 1'b1);
        check("ov_set", overflow, 1);
        check("ov_count", rx_count, 16);
        check("ov_head", rx_data, 8'h10);
        for (int i = 0; i < 16; i++) pop_rx($sformatf("ov_drain%0d", i), 8'h10 + 8'(i));
        check("ov_drained", rx_count, 0);
        clear_errs();
        check("ov_clear", overflow, 0);

        rxd_drv = 1'b0;
        cyc(4);
        rxd_drv = 1'b1;
        cyc(40);
        check("gl_count", rx_count, 0);
        check("gl_errs", {framing_err, parity_err, overflow}, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("gl_after", rx_count, 1);
        pop_rx("gl_data", 8'h5A);

        mr_pulse(1'b0, low);
        check("mr_single", low, 10);
        check("mr_high", module_reset_n, 1);
        cyc(3);
        mr_pulse(1'b1, low);
        check("mr_restart", low, 15);
        check("mr_high2", module_reset_n, 1);

        push_tx(8'h0F);
        cyc(3);
        check("mid_tx_low", txd, 0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_tx_rst", txd, 1);
        check("mid_tx_cnt", tx_count, 0);
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        check("post_rst_txd", txd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
